material_scan: RTL and testbench

Sequential material evaluator between the board RAM and the search/evaluation controller. On `start`, reads all 64 squares through the board RAM's synchronous read port, one square per cycle. Accumulates a signed white-minus-black material score and presents it with a one-cycle `score_valid` pulse. This replaces the flat 64-way combinational sum with a small, timing-friendly pipeline.

---
 rtl/chess_pkg.sv | 33 +++
 rtl/material_scan_if.sv | 36 +++
 rtl/material_weight.sv | 19 +
 rtl/material_scan.sv | 97 +++++++++
 tb/tb_material_scan.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Board encoding shared by the move generator, board RAM and evaluators.
// Cells are {colour, piece code}; square 0 is a1.
package chess_pkg;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_e;

  typedef logic [5:0] square_t;
  typedef logic [3:0] cell_t;

  localparam int NUM_SQUARES = 64;

  // Indexed by piece code; code 7 is reserved and weighs nothing.
  localparam logic [3:0] piece_weight [0:7] = '{4'd0, 4'd1, 4'd3, 4'd3, 4'd5, 4'd10, 4'd0, 4'd0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/material_scan_if.sv
// Controller / board RAM side of the material scanner: scan request, RAM read port, result.
interface material_scan_if
  import chess_pkg::*;
#(
  parameter int SCORE_W = 16
);

  logic                      start;
  logic                      busy;
  logic                      board_rd_en;
  square_t                   board_addr;
  cell_t                     board_rd_data;
  logic signed [SCORE_W-1:0] score;
  logic                      score_valid;

  modport slave (
    input  start,
    input  board_rd_data,
    output busy,
    output board_rd_en,
    output board_addr,
    output score,
    output score_valid
  );

  modport master (
    output start,
    output board_rd_data,
    input  busy,
    input  board_rd_en,
    input  board_addr,
    input  score,
    input  score_valid
  );

endinterface

// File: rtl/material_weight.sv
// Combinational cell -> signed material contribution, white positive.
module material_weight
  import chess_pkg::*;
#(
  parameter int SCORE_W = 16
) (
  input  cell_t                     cell_i,
  output logic signed [SCORE_W-1:0] contrib_o
);

  logic [SCORE_W-1:0] mag;

  // Empty and reserved codes weigh zero, so negating them for black is harmless.
  always_comb begin
    mag       = {{(SCORE_W-4){1'b0}}, piece_weight[cell_i[2:0]]};
    contrib_o = (cell_i[3] == COLOR_BLACK) ? -mag : mag;
  end

endmodule

// File: rtl/material_scan.sv
// Walks all 64 squares through the board RAM read port and accumulates material.
// Result appears 66 cycles after start with a one-cycle score_valid pulse.
module material_scan
  import chess_pkg::*;
#(
  parameter int SCORE_W = 16,
  parameter int RD_LAT  = 1
) (
  input logic           clk,
  input logic           rst_n,
  material_scan_if.slave bus
);

  generate
    if (RD_LAT != 1) begin : g_bad_rd_lat
      $error("material_scan supports only RD_LAT == 1");
    end
  endgenerate

  scan_state_e               state_q;
  square_t                   addr_q;
  logic                      rd_en_q;
  logic                      busy_q;
  logic                      dvld_q;
  logic signed [SCORE_W-1:0] acc_q;
  logic signed [SCORE_W-1:0] acc_d;
  logic signed [SCORE_W-1:0] score_q;
  logic                      score_vld_q;
  logic signed [SCORE_W-1:0] contrib;

  material_weight #(.SCORE_W(SCORE_W)) u_weight (
    .cell_i    (bus.board_rd_data),
    .contrib_o (contrib)
  );

  // dvld_q marks the cycle in which the RAM presents data for last cycle's strobe.
  always_comb begin
    acc_d = acc_q;
    if (dvld_q) begin
      acc_d = acc_q + contrib;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      dvld_q      <= 1'b0;
      acc_q       <= '0;
      score_q     <= '0;
      score_vld_q <= 1'b0;
    end else begin
      dvld_q      <= rd_en_q;
      acc_q       <= acc_d;
      score_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_SCAN;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            addr_q  <= '0;
            acc_q   <= '0;
          end
        end
        ST_SCAN: begin
          if (addr_q == square_t'(NUM_SQUARES - 1)) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 6'd1;
          end
        end
        ST_DRAIN: begin
          // Last datum is folded in here so score is visible during DONE.
          state_q     <= ST_DONE;
          score_q     <= acc_d;
          score_vld_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.board_rd_en = rd_en_q;
  assign bus.board_addr  = addr_q;
  assign bus.score       = score_q;
  assign bus.score_valid = score_vld_q;

endmodule

// File: tb/tb_material_scan.sv
// Directed and randomized boards against a table-driven material sum model.
module tb_material_scan;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [3:0] board_mem [64];
  int         weights [8] = '{0, 1, 3, 3, 5, 10, 0, 0};

  material_scan_if #(.SCORE_W(16)) bus ();

  material_scan #(.SCORE_W(16), .RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM with a one-cycle synchronous read.
  always @(posedge clk) begin
    if (bus.board_rd_en) bus.board_rd_data <= board_mem[bus.board_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_score();
    int sum;
    sum = 0;
    for (int s = 0; s < 64; s++) begin
      if (board_mem[s][3]) sum -= weights[board_mem[s][2:0]];
      else                 sum += weights[board_mem[s][2:0]];
    end
    return sum[15:0];
  endfunction

  task automatic load_start_pos();
    int back [8];
    back = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int s = 0; s < 64; s++) board_mem[s] = 4'h0;
    for (int f = 0; f < 8; f++) begin
      board_mem[f]      = 4'(back[f]);
      board_mem[8 + f]  = 4'h1;
      board_mem[48 + f] = 4'h9;
      board_mem[56 + f] = 4'h8 | 4'(back[f]);
    end
  endtask

  task automatic run_scan(input string name, input int glitch_at, input logic [15:0] exp);
    int   cyc;
    int   addr_exp;
    bit   addr_ok;
    bit   busy_ok;
    bit   got;
    int   extra;
    logic [15:0] held;
    addr_exp = 0; addr_ok = 1; busy_ok = 1; got = 0; extra = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 1;
    while (cyc <= 200) begin
      if (bus.board_rd_en) begin
        if (addr_exp > 63 || bus.board_addr != 6'(addr_exp)) addr_ok = 0;
        addr_exp++;
      end
      if (!bus.busy) busy_ok = 0;
      if (bus.score_valid) begin
        got = 1;
        break;
      end
      bus.start = (cyc == glitch_at);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({name, "_valid_seen"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'd66);
    check({name, "_score"}, {16'h0, bus.score}, {16'h0, exp});
    check({name, "_addr_sweep"}, 32'(addr_ok && addr_exp == 64), 32'd1);
    check({name, "_busy_window"}, 32'(busy_ok), 32'd1);
    held = bus.score;
    @(negedge clk);
    check({name, "_busy_drop"}, 32'(bus.busy), 32'd0);
    for (int i = 0; i < 80; i++) begin
      if (bus.score_valid || bus.busy || bus.score !== held) extra++;
      @(negedge clk);
    end
    check({name, "_quiet_hold"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int          cyc;
    int          pulses [3];
    int          np;
    int          bad;
    logic [15:0] exp;
    logic [3:0]  odd [4];
    checks = 0; errors = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.board_rd_data = 4'h0;
    for (int s = 0; s < 64; s++) board_mem[s] = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_en", 32'(bus.board_rd_en), 32'd0);
    check("rst_addr", 32'(bus.board_addr), 32'd0);
    check("rst_score", {16'h0, bus.score}, 32'd0);
    check("rst_valid", 32'(bus.score_valid), 32'd0);
    rst_n = 1'b1;

    load_start_pos();
    check("model_start", {16'h0, ref_score()}, 32'h0000);
    run_scan("startpos", 0, ref_score());

    board_mem[59] = 4'h0;
    check("model_noqueen", {16'h0, ref_score()}, 32'h000A);
    run_scan("no_bq", 20, ref_score());

    for (int s = 0; s < 64; s++) board_mem[s] = 4'h0;
    board_mem[4] = 4'h6; board_mem[60] = 4'hC; board_mem[57] = 4'hA;
    check("model_kr", {16'h0, ref_score()}, 32'hFFF8);
    run_scan("k_vs_rn", 0, ref_score());

    // Reset in cycle 30 of a scan, with a nonzero score left from the previous one.
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_rd_en", 32'(bus.board_rd_en), 32'd0);
    check("midrst_addr", 32'(bus.board_addr), 32'd0);
    check("midrst_score", {16'h0, bus.score}, 32'd0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.score_valid || bus.busy) bad++;
      @(negedge clk);
    end
    check("midrst_no_valid", 32'(bad), 32'd0);
    run_scan("after_rst", 0, ref_score());

    odd = '{4'h0, 4'h8, 4'h7, 4'hF};
    for (int s = 0; s < 64; s++) board_mem[s] = odd[$urandom_range(0, 3)];
    run_scan("empty_rsvd", 0, 16'h0000);

    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 64; s++) board_mem[s] = 4'($urandom_range(0, 15));
      run_scan($sformatf("rand%0d", r), (r == 1) ? 40 : 0, ref_score());
    end

    // Start held high: one result every 67 cycles.
    load_start_pos();
    board_mem[12] = 4'h0;
    exp = ref_score();
    check("model_nopawn", {16'h0, exp}, 32'h0000FFFF);
    @(negedge clk); bus.start = 1'b1;
    np = 0; bad = 0; cyc = 0;
    while (np < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.score_valid) begin
        if (bus.score !== exp) bad++;
        pulses[np] = cyc;
        np++;
      end
    end
    bus.start = 1'b0;
    check("held_pulses", 32'(np), 32'd3);
    check("held_scores", 32'(bad), 32'd0);
    if (np == 3) begin
      check("held_first", 32'(pulses[0]), 32'd66);
      check("held_period1", 32'(pulses[1] - pulses[0]), 32'd67);
      check("held_period2", 32'(pulses[2] - pulses[1]), 32'd67);
    end
    repeat (140) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
